// File: rtl/dtcm_responder.sv
// dtcm_responder: in-order data-side responder backed by a word-organised DTCM.
// Define DTCM_STAT_EN to add the accepted read/write counters stat_rd_cnt/stat_wr_cnt.
module dtcm_responder #(
   parameter int RAM_AW  = 10,
   parameter int LATENCY = 1,
   parameter int QDEPTH  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_valid,
   input  logic        data_op,
   input  logic [2:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   input  logic [31:0] data_addr,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        data_err,
   input  logic        rsp_ready
`ifdef DTCM_STAT_EN
   ,
   output logic [31:0] stat_rd_cnt,
   output logic [31:0] stat_wr_cnt
`endif
);

   localparam int CW    = $clog2(QDEPTH + 1);
   localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int WORDS = 1 << RAM_AW;
   localparam logic [CW-1:0] QD    = CW'(QDEPTH);
   localparam logic [PW-1:0] PLAST = PW'(QDEPTH - 1);

   logic [31:0]       mem [WORDS];
   logic [31:0]       fdata [QDEPTH];
   logic              ferr [QDEPTH];
   logic [CW-1:0]     count;
   logic [CW-1:0]     fcnt;
   logic [PW-1:0]     wptr;
   logic [PW-1:0]     rptr;
   logic              accept;
   logic              pop;
   logic              in_range;
   logic [RAM_AW-1:0] idx;
   logic [31:0]       rd_word;
   logic              rsp_err;
   logic              push;
   logic [31:0]       push_rdata;
   logic              push_err;
   logic              unused_bits;

   // size and byte offset carry no information for a word-wide lane-aligned port
   assign unused_bits = ^{data_size, data_addr[1:0]};

   assign data_addr_ok = !reset && (count < QD);
   assign accept       = data_valid && data_addr_ok;
   assign data_data_ok = (fcnt != '0);
   assign pop          = data_data_ok && rsp_ready;

   assign in_range = (data_addr[31:RAM_AW+2] == '0);
   assign idx      = data_addr[RAM_AW+1:2];
   assign rsp_err  = !in_range;
   assign rd_word  = (!data_op && in_range) ? mem[idx] : 32'h0;

   always_ff @(posedge clk) begin
      if (accept && data_op && in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (data_wstrb[i]) begin
               mem[idx][8*i +: 8] <= data_wdata[8*i +: 8];
            end
         end
      end
   end

   generate
      if (LATENCY > 1) begin : g_pipe
         localparam int PD = LATENCY - 1;
         logic [PD-1:0] p_valid;
         logic [PD-1:0] p_err;
         logic [31:0]   p_rdata [PD];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               p_valid <= '0;
               p_err   <= '0;
               for (int i = 0; i < PD; i++) begin
                  p_rdata[i] <= 32'h0;
               end
            end else begin
               p_valid[0] <= accept;
               p_err[0]   <= rsp_err;
               p_rdata[0] <= rd_word;
               for (int i = 1; i < PD; i++) begin
                  p_valid[i] <= p_valid[i-1];
                  p_err[i]   <= p_err[i-1];
                  p_rdata[i] <= p_rdata[i-1];
               end
            end
         end

         assign push       = p_valid[PD-1];
         assign push_err   = p_err[PD-1];
         assign push_rdata = p_rdata[PD-1];
      end else begin : g_direct
         assign push       = accept;
         assign push_err   = rsp_err;
         assign push_rdata = rd_word;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         fcnt  <= '0;
         wptr  <= '0;
         rptr  <= '0;
      end else begin
         if (push) begin
            wptr <= (wptr == PLAST) ? '0 : wptr + 1'b1;
         end
         if (pop) begin
            rptr <= (rptr == PLAST) ? '0 : rptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fcnt <= fcnt + 1'b1;
            2'b01:   fcnt <= fcnt - 1'b1;
            default: fcnt <= fcnt;
         endcase
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // count bounds pipeline plus queue, so a push never finds the FIFO full
   always_ff @(posedge clk) begin
      if (push) begin
         fdata[wptr] <= push_rdata;
         ferr[wptr]  <= push_err;
      end
   end

   assign data_rdata = data_data_ok ? fdata[rptr] : 32'h0;
   assign data_err   = data_data_ok ? ferr[rptr] : 1'b0;

`ifdef DTCM_STAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_rd_cnt <= 32'h0;
         stat_wr_cnt <= 32'h0;
      end else if (accept) begin
         if (data_op) begin
            stat_wr_cnt <= stat_wr_cnt + 32'h1;
         end else begin
            stat_rd_cnt <= stat_rd_cnt + 32'h1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dtcm_responder.sv
// tb_dtcm_responder: two responders (latency 1/depth 2 and latency 3/depth 4)
// on shared stimulus, checked every cycle against a queue-based model.
module tb_dtcm_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        data_valid;
   logic        data_op;
   logic [2:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic [31:0] data_addr;
   logic        rsp_ready;
   logic [1:0]  aok;
   logic [1:0]  dok;
   logic [1:0]  er;
   logic [1:0][31:0] rd;

   int checks = 0;
   int fails  = 0;
   int t      = 0;

   always #5 clk = ~clk;

   dtcm_responder u_dut0 (
      .clk(clk), .reset(reset),
      .data_valid(data_valid), .data_op(data_op),
      .data_size(data_size), .data_wstrb(data_wstrb),
      .data_wdata(data_wdata), .data_addr(data_addr),
      .data_addr_ok(aok[0]), .data_data_ok(dok[0]),
      .data_rdata(rd[0]), .data_err(er[0]),
      .rsp_ready(rsp_ready)
   );

   dtcm_responder #(.RAM_AW(10), .LATENCY(3), .QDEPTH(4)) u_dut1 (
      .clk(clk), .reset(reset),
      .data_valid(data_valid), .data_op(data_op),
      .data_size(data_size), .data_wstrb(data_wstrb),
      .data_wdata(data_wdata), .data_addr(data_addr),
      .data_addr_ok(aok[1]), .data_data_ok(dok[1]),
      .data_rdata(rd[1]), .data_err(er[1]),
      .rsp_ready(rsp_ready)
   );

   typedef struct {
      int          rdy;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t        mq [2][$];
   logic [31:0] mem_m [2][1024];
   int          cnt_m [2];
   int          lat_m [2] = '{1, 3};
   int          qd_m  [2] = '{2, 4};

   task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
      end
   endtask

   // model: each accepted request becomes a response due LATENCY cycles later
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic e_aok, e_dok, acc, pp, inr;
         int   wi;
         rsp_t r;
         if (reset) begin
            mq[k].delete();
            cnt_m[k] = 0;
            chk("rst_addr_ok", k, 32'(aok[k]), 0);
            chk("rst_data_ok", k, 32'(dok[k]), 0);
            chk("rst_rdata", k, rd[k], 0);
            chk("rst_err", k, 32'(er[k]), 0);
         end else begin
            e_aok = cnt_m[k] < qd_m[k];
            e_dok = (mq[k].size() > 0) && (mq[k][0].rdy <= t);
            chk("addr_ok", k, 32'(aok[k]), 32'(e_aok));
            chk("data_ok", k, 32'(dok[k]), 32'(e_dok));
            if (e_dok && dok[k]) begin
               chk("rdata", k, rd[k], mq[k][0].rdata);
               chk("err", k, 32'(er[k]), 32'(mq[k][0].err));
            end
            acc = data_valid && e_aok;
            pp  = e_dok && rsp_ready;
            if (pp) begin
               void'(mq[k].pop_front());
               cnt_m[k]--;
            end
            if (acc) begin
               inr = (data_addr[31:12] == 20'h0);
               wi  = int'(data_addr[11:2]);
               r.rdy   = t + lat_m[k];
               r.err   = !inr;
               r.rdata = 32'h0;
               if (data_op && inr) begin
                  for (int b = 0; b < 4; b++) begin
                     if (data_wstrb[b]) mem_m[k][wi][8*b +: 8] = data_wdata[8*b +: 8];
                  end
               end else if (!data_op && inr) begin
                  r.rdata = mem_m[k][wi];
               end
               mq[k].push_back(r);
               cnt_m[k]++;
            end
         end
      end
      t++;
   end

   task automatic idle(int n);
      data_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic req(logic op, logic [31:0] a, logic [3:0] s, logic [31:0] d);
      int n;
      data_valid = 1'b1;
      data_op    = op;
      data_addr  = a;
      data_wstrb = s;
      data_wdata = d;
      n = 0;
      forever begin
         @(negedge clk);
         if (aok[0]) break;
         n++;
         if (n > 20) begin
            checks++;
            fails++;
            $display("FAIL req_timeout dut0: got no addr_ok expected addr_ok");
            break;
         end
      end
      @(posedge clk);
      #1 data_valid = 1'b0;
   endtask

   task automatic wait_rsp(string nm, logic [31:0] exp_rd, logic exp_err);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (dok[0]) begin
            chk(nm, 0, rd[0], exp_rd);
            chk({nm, "_err"}, 0, 32'(er[0]), 32'(exp_err));
            break;
         end
         n++;
         if (n > 10) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout dut0: got no data_ok expected data_ok", nm);
            break;
         end
      end
   endtask

   initial begin
      int f0, f1, r, w;
      reset      = 1'b1;
      data_valid = 1'b0;
      data_op    = 1'b0;
      data_size  = 3'd2;
      data_wstrb = 4'h0;
      data_wdata = 32'h0;
      data_addr  = 32'h0;
      rsp_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         req(1'b1, 32'(i * 4), 4'hF, 32'hC0DE_0000 | 32'(i));
      end
      idle(4);

      req(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
      req(1'b0, 32'h10, 4'h0, 32'h0);
      wait_rsp("rd_after_wr", 32'hDEAD_BEEF, 1'b0);
      idle(4);

      req(1'b1, 32'h20, 4'hF, 32'h1122_3344);
      req(1'b1, 32'h23, 4'b1000, 32'h5A00_0000);
      req(1'b0, 32'h20, 4'h0, 32'h0);
      wait_rsp("byte_wr", 32'h5A22_3344, 1'b0);
      idle(4);

      req(1'b1, 32'h0, 4'hF, 32'h0BAD_F00D);
      idle(4);
      req(1'b0, 32'h1000, 4'h0, 32'h0);
      wait_rsp("oor_rd", 32'h0, 1'b1);
      req(1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF);
      wait_rsp("oor_wr", 32'h0, 1'b1);
      req(1'b0, 32'h0, 4'h0, 32'h0);
      wait_rsp("word0_kept", 32'h0BAD_F00D, 1'b0);
      idle(4);

      req(1'b0, 32'h4, 4'h0, 32'h0);
      f0 = 0;
      f1 = 0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (dok[0] && f0 == 0) f0 = n;
         if (dok[1] && f1 == 0) f1 = n;
      end
      chk("latency1", 0, 32'(f0), 1);
      chk("latency3", 1, 32'(f1), 3);
      idle(4);

      rsp_ready = 1'b0;
      req(1'b0, 32'h8, 4'h0, 32'h0);
      req(1'b0, 32'hC, 4'h0, 32'h0);
      data_valid = 1'b1;
      data_op    = 1'b0;
      data_addr  = 32'h14;
      @(negedge clk);
      chk("bp_block", 0, 32'(aok[0]), 0);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_head", 0, rd[0], 32'hC0DE_0002);
      chk("bp_still_blocked", 0, 32'(aok[0]), 0);
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_accept3", 0, 32'(aok[0]), 1);
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      rsp_ready  = 1'b1;
      wait_rsp("bp_second", 32'hC0DE_0003, 1'b0);
      wait_rsp("bp_third", 32'hC0DE_0005, 1'b0);
      idle(8);

      rsp_ready = 1'b0;
      req(1'b0, 32'h20, 4'h0, 32'h0);
      req(1'b0, 32'h24, 4'h0, 32'h0);
      #1 reset = 1'b1;
      #1;
      chk("rst_drop_dok", 0, 32'(dok[0]), 0);
      chk("rst_drop_dok", 1, 32'(dok[1]), 0);
      chk("rst_drop_aok", 0, 32'(aok[0]), 0);
      repeat (2) @(posedge clk);
      #1;
      reset     = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_aok", 0, 32'(aok[0]), 1);
      chk("post_rst_dok", 0, 32'(dok[0]), 0);
      req(1'b0, 32'h20, 4'h0, 32'h0);
      wait_rsp("mem_kept", 32'h5A22_3344, 1'b0);
      idle(4);

      for (int n = 0; n < 4000; n++) begin
         @(posedge clk);
         #1;
         if (n == 2000) reset = 1'b1;
         if (n == 2003) reset = 1'b0;
         data_valid = ($urandom_range(0, 99) < 60);
         data_op    = 1'($urandom_range(0, 1));
         data_size  = 3'($urandom_range(0, 2));
         data_wstrb = 4'($urandom);
         data_wdata = $urandom;
         r = $urandom_range(0, 19);
         w = $urandom_range(0, 15);
         if (r == 0) data_addr = 32'h1000 | 32'(w << 2);
         else if (r == 1) data_addr = $urandom | 32'h8000_0000;
         else data_addr = 32'(w << 2) | 32'($urandom_range(0, 3));
         rsp_ready = ($urandom_range(0, 99) < 65);
      end
      rsp_ready = 1'b1;
      idle(12);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
